// File: rtl/cache_data_pkg.sv
// Shared types, sizing defaults and helpers for the multi-way cache data array.
package cache_data_pkg;

    localparam int unsigned DEF_S_OFFSET = 5;
    localparam int unsigned DEF_S_INDEX  = 3;
    localparam int unsigned DEF_NUM_WAYS = 2;

    localparam int unsigned DEF_S_MASK   = 2 ** DEF_S_OFFSET;
    localparam int unsigned DEF_S_LINE   = 8 * DEF_S_MASK;
    localparam int unsigned DEF_NUM_SETS = 2 ** DEF_S_INDEX;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dclr_state_t;

    // Even parity: the stored bit makes the 9-bit group have an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/multiway_data_array_if.sv
// Request/response bundle between the cache controller (master) and the data array (slave).
interface multiway_data_array_if
    import cache_data_pkg::*;
#(
    parameter int unsigned s_offset = DEF_S_OFFSET,
    parameter int unsigned s_index  = DEF_S_INDEX,
    parameter int unsigned num_ways = DEF_NUM_WAYS
);
    localparam int unsigned S_MASK = 2 ** s_offset;
    localparam int unsigned S_LINE = 8 * S_MASK;
    localparam int unsigned WAY_W  = (num_ways > 1) ? $clog2(num_ways) : 1;

    logic                         read;
    logic [s_index-1:0]           rindex;
    logic [S_MASK-1:0]            write_en;
    logic [WAY_W-1:0]             wway;
    logic [s_index-1:0]           windex;
    logic [S_LINE-1:0]            datain;
    logic [num_ways*S_LINE-1:0]   dataout;
    logic                         rvalid;
    logic                         busy;
    logic [num_ways-1:0]          parity_err;

    modport master (
        output read, rindex, write_en, wway, windex, datain,
        input  dataout, rvalid, busy, parity_err
    );

    modport slave (
        input  read, rindex, write_en, wway, windex, datain,
        output dataout, rvalid, busy, parity_err
    );

endinterface

// File: rtl/data_way_bank.sv
// One cache way: num_sets lines with byte-masked write and combinational read.
// With DATA_ARRAY_PARITY_EN defined, an even-parity bit per byte is stored and checked.
module data_way_bank
    import cache_data_pkg::*;
#(
    parameter  int unsigned s_offset = DEF_S_OFFSET,
    parameter  int unsigned s_index  = DEF_S_INDEX,
    localparam int unsigned S_MASK   = 2 ** s_offset,
    localparam int unsigned S_LINE   = 8 * S_MASK,
    localparam int unsigned NUM_SETS = 2 ** s_index
) (
    input  logic                clk,
    input  logic [S_MASK-1:0]   wmask,
    input  logic [s_index-1:0]  waddr,
    input  logic [S_LINE-1:0]   wdata,
    input  logic [s_index-1:0]  raddr,
    output logic [S_LINE-1:0]   rdata
`ifdef DATA_ARRAY_PARITY_EN
    ,
    output logic [S_MASK-1:0]   rerr
`endif
);

    logic [S_LINE-1:0] mem [NUM_SETS];

    // Byte-masked line write; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(S_MASK); i++) begin
            if (wmask[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

`ifdef DATA_ARRAY_PARITY_EN
    logic [S_MASK-1:0] par [NUM_SETS];

    // Parity bits follow the same byte mask as the data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(S_MASK); i++) begin
            if (wmask[i]) begin
                par[waddr][i] <= byte_parity(wdata[8*i +: 8]);
            end
        end
    end

    // Per-byte check of the addressed line.
    always_comb begin
        rerr = '0;
        for (int i = 0; i < int'(S_MASK); i++) begin
            rerr[i] = byte_parity(rdata[8*i +: 8]) ^ par[raddr][i];
        end
    end
`endif

endmodule

// File: rtl/multiway_data_array.sv
// N-way cache data array: registered all-ways read, byte-masked write-first forwarding,
// and a set-by-set clear sequencer after reset. Optional per-byte parity via DATA_ARRAY_PARITY_EN.
module multiway_data_array
    import cache_data_pkg::*;
#(
    parameter int unsigned s_offset = DEF_S_OFFSET,
    parameter int unsigned s_index  = DEF_S_INDEX,
    parameter int unsigned num_ways = DEF_NUM_WAYS
) (
    input  logic                    clk,
    input  logic                    rst,
    multiway_data_array_if.slave    bus
);

    localparam int unsigned S_MASK   = 2 ** s_offset;
    localparam int unsigned S_LINE   = 8 * S_MASK;
    localparam int unsigned NUM_SETS = 2 ** s_index;
    localparam int unsigned WAY_W    = (num_ways > 1) ? $clog2(num_ways) : 1;

    dclr_state_t                state, state_n;
    logic [s_index-1:0]         clr_idx, clr_idx_n;

    logic [S_MASK-1:0]          wmask_c [num_ways];
    logic [s_index-1:0]         waddr_c;
    logic [S_LINE-1:0]          wdata_c;
    logic [S_LINE-1:0]          rline_c [num_ways];

    logic                       ready_c;
    logic                       rd_go_c;
    logic                       fwd_en_c;
    logic [num_ways*S_LINE-1:0] dout_n_c;

    logic [num_ways*S_LINE-1:0] dout_q;
    logic                       rvalid_q;
    logic                       busy_q;

    assign ready_c  = (state == READY);
    assign rd_go_c  = ready_c & bus.read;
    assign fwd_en_c = ready_c & (bus.windex == bus.rindex);

    // Clear sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_n;
            clr_idx <= clr_idx_n;
        end
    end

    // Next state and bank write steering: clear sweep or decoded user write.
    always_comb begin
        state_n   = state;
        clr_idx_n = clr_idx;
        waddr_c   = bus.windex;
        wdata_c   = bus.datain;
        for (int w = 0; w < int'(num_ways); w++) begin
            wmask_c[w] = '0;
        end
        case (state)
            CLEAR: begin
                waddr_c   = clr_idx;
                wdata_c   = '0;
                for (int w = 0; w < int'(num_ways); w++) begin
                    wmask_c[w] = '1;
                end
                clr_idx_n = clr_idx + s_index'(1);
                if (clr_idx == s_index'(NUM_SETS - 1)) begin
                    state_n = READY;
                end
            end
            READY: begin
                // An out-of-range way matches no bank, so the write is dropped.
                for (int w = 0; w < int'(num_ways); w++) begin
                    if (bus.wway == WAY_W'(w)) begin
                        wmask_c[w] = bus.write_en;
                    end
                end
            end
            default: begin
                state_n = CLEAR;
            end
        endcase
    end

`ifdef DATA_ARRAY_PARITY_EN
    logic [S_MASK-1:0]   rerr_c [num_ways];
    logic [num_ways-1:0] perr_n_c;
    logic [num_ways-1:0] perr_q;
`endif

    for (genvar w = 0; w < int'(num_ways); w++) begin : g_way
        data_way_bank #(
            .s_offset (s_offset),
            .s_index  (s_index)
        ) u_bank (
            .clk   (clk),
            .wmask (wmask_c[w]),
            .waddr (waddr_c),
            .wdata (wdata_c),
            .raddr (bus.rindex),
            .rdata (rline_c[w])
`ifdef DATA_ARRAY_PARITY_EN
            ,
            .rerr  (rerr_c[w])
`endif
        );
    end

    // Write-first merge: bytes being written this edge to the read set replace stored bytes.
    always_comb begin
        dout_n_c = '0;
        for (int w = 0; w < int'(num_ways); w++) begin
            for (int i = 0; i < int'(S_MASK); i++) begin
                dout_n_c[w*S_LINE + 8*i +: 8] = (fwd_en_c && wmask_c[w][i]) ?
                                                bus.datain[8*i +: 8] : rline_c[w][8*i +: 8];
            end
        end
    end

    // Read response registers; dataout holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            rvalid_q <= rd_go_c;
            busy_q   <= (state_n == CLEAR);
            if (rd_go_c) begin
                dout_q <= dout_n_c;
            end
        end
    end

`ifdef DATA_ARRAY_PARITY_EN
    // Forwarded bytes are fresh data and cannot carry a stored-parity error.
    always_comb begin
        perr_n_c = '0;
        for (int w = 0; w < int'(num_ways); w++) begin
            perr_n_c[w] = |(rerr_c[w] & ~(fwd_en_c ? wmask_c[w] : S_MASK'(0)));
        end
    end

    // Parity error flags travel with rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= '0;
        end else begin
            perr_q <= rd_go_c ? perr_n_c : '0;
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = '0;
`endif

    assign bus.dataout = dout_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.busy    = busy_q;

endmodule

// File: doc/multiway_data_array.md
Name: multiway_data_array

Overview:
- Next-generation cache data store: N-way, byte-maskable line storage with a registered (1-cycle) read port and a separate write port.
- Zeroes itself after reset with a set-by-set clear sequencer instead of a flop-wide reset.
- Returns all ways of a set together so the cache datapath can mux by tag hit.
- Sits between the cache control FSM and the hit/way-select mux, replacing the single-way, combinational-read data array.

Parameters:
s_offset, 5, log2 bytes per line (line = 8*2**s_offset bits)
s_index, 3, log2 number of sets
num_ways, 2, ways per set (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = reset)
read  in  1  read request, sampled on rising clk
rindex  in  s_index  read set
write_en  in  2**s_offset  per-byte write mask; all-zero = no write
wway  in  clog2(num_ways) (min 1)  way to write
windex  in  s_index  write set
datain  in  8*2**s_offset  write line
dataout  out  num_ways*8*2**s_offset  registered read data; way w at [w*s_line +: s_line]
rvalid  out  1  dataout updated by the read issued last cycle
busy  out  1  clear sequencer active; requests ignored
parity_err  out  num_ways  per-way parity error, valid with rvalid

Behaviour:
- Async reset (rst=0): state=CLEAR, clr_idx=0, dataout=0, rvalid=0, busy=1, parity_err=0. Storage is not reset by rst.
- FSM states: CLEAR and READY.
- CLEAR, each cycle:
  - Writes zero (and matching parity) to all ways of set clr_idx, then clr_idx++.
  - On clr_idx==num_sets-1 the next state is READY.
  - The clear takes exactly num_sets cycles after rst deasserts; busy drops in the first READY cycle.
  - read and write_en are ignored: no storage change, rvalid stays 0.
- READY, write:
  - If write_en != 0, byte i of way wway, set windex takes datain byte i where write_en[i]=1.
  - Other bytes, ways and sets are unchanged.
  - Commits on the rising edge.
- READY, read:
  - read=1 at edge t → rvalid=1 and dataout = all ways of rindex during cycle t+1.
  - read=0 → rvalid=0 next cycle; dataout holds its last value.
- Same-edge read and write to the same set: write-first. dataout shows the newly written bytes for way wway, and old contents for unmasked bytes and other ways.
- Read at t+1 of a set written at t: returns the new data (storage already updated).
- Back-to-back reads: one per cycle, full throughput, no stalls.
- Reset asserted mid-clear or mid-read: aborts immediately; the clear restarts at set 0.
- wway >= num_ways (non-power-of-2 num_ways): the write is dropped.

Optional Feature:
DATA_ARRAY_PARITY_EN
- Defined:
  - One even-parity bit is stored per byte per way, written alongside the data.
  - On read, parity_err[w]=1 if any byte of way w fails its check; registered with rvalid.
  - parity_err is 0 when rvalid=0.
- Undefined: no parity storage; parity_err is tied to 0. The port list is identical either way.

Decomposition:
- Package cache_data_pkg holds:
  - typedef enum {CLEAR, READY} dclr_state_t;
  - function byte_parity(logic [7:0]);
  - helper localparams deriving s_mask, s_line and num_sets from s_offset/s_index.
- Sub-module data_way_bank holds one way: num_sets x s_line storage, byte-masked write, plus the parity bits under the macro.
- The top level instantiates num_ways banks via generate and owns:
  - the clear FSM;
  - way decode;
  - write-first forwarding;
  - the output registers.

Test Plan:
- Reset, defaults (2 ways, 8 sets): release rst → busy=1 for exactly 8 cycles, then 0. read set 0..7 → dataout all zero, rvalid=1 one cycle after each read.
- Masked write: write_en=32'h0000_000F, wway=1, windex=3, datain=all 8'hAA, then read 3 → way1 bytes 0-3 = AA, bytes 4-31 = 00; way0 all 00.
- Write-first: same edge write_en=all-ones, wway=0, windex=5, datain=pattern P, and read rindex=5 → next cycle way0=P. Set 5 with a different rindex → old data.
- Busy ignore: during CLEAR assert read=1 and write_en=all-ones to set 2 → rvalid stays 0. After READY, set 2 reads all zero.
- Reset mid-clear: drop rst at clear cycle 4 → busy=1, rvalid=0 immediately. Release → 8 full clear cycles again.
- Parity (macro on): force a stored bit flip in way 1, set 6 via backdoor; read 6 → parity_err=2'b10 with rvalid=1. Macro off: parity_err=0 always.
